fifo_ptr_ctrl: RTL and testbench

//  Write/read pointer generator and storage for the synchronous FIFO.

---
 rtl/fifo_pkg.sv | 15 +
 rtl/fifo_regfile.sv | 37 +++
 rtl/fifo_ptr_ctrl.sv | 109 ++++++++++
 tb/tb_fifo_ptr_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared types and defaults for the synchronous FIFO pointer and status blocks.
package fifo_pkg;

  localparam int DATA_SIZE_DEF  = 8;
  localparam int ADDR_DEPTH_DEF = 8;
  localparam int ADDR_W_DEF     = $clog2(ADDR_DEPTH_DEF);

  typedef logic [ADDR_W_DEF-1:0] ptr_t;
  typedef logic [ADDR_W_DEF:0]   cnt_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(ADDR_DEPTH_DEF - 1)) ? '0 : ptr_t'(p + 1'b1);
  endfunction

endpackage

// File: rtl/fifo_regfile.sv
// FIFO storage: synchronous write port, registered read port.
// Only the read-data register is reset; the array itself is never cleared.
module fifo_regfile #(
  parameter int DATA_SIZE  = 8,
  parameter int ADDR_DEPTH = 8,
  localparam int ADDR_W    = $clog2(ADDR_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [DATA_SIZE-1:0] wdata,
  input  logic                 re,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [DATA_SIZE-1:0] rdata
);

  logic [DATA_SIZE-1:0] mem_q [ADDR_DEPTH];
  logic [DATA_SIZE-1:0] rdata_d, rdata_q;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem_q[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// FIFO write/read pointer control: accept logic, occupancy, registered flags,
// sticky error flags, and the storage array instance.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DATA_SIZE  = DATA_SIZE_DEF,
  parameter int ADDR_DEPTH = ADDR_DEPTH_DEF,
  parameter int AF_LEVEL   = 6,
  localparam int ADDR_W    = $clog2(ADDR_DEPTH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [DATA_SIZE-1:0] wr_data,
  input  logic                 rd_en,
  input  logic                 clr_err,
  output logic [DATA_SIZE-1:0] rd_data,
  output logic                 rd_valid,
  output logic [ADDR_W-1:0]    wr_ptr,
  output logic [ADDR_W-1:0]    rd_ptr,
  output logic [ADDR_W:0]      fifo_count,
  output logic                 fifo_full,
  output logic                 fifo_empty,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow
);

  localparam logic [ADDR_W:0] CNT_FULL = (ADDR_W+1)'(ADDR_DEPTH);
  localparam logic [ADDR_W:0] CNT_AF   = (ADDR_W+1)'(AF_LEVEL);

  logic [ADDR_W-1:0] wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
  logic [ADDR_W:0]   count_d, count_q;
  logic              full_d, full_q, empty_d, empty_q, af_d, af_q;
  logic              ovf_d, ovf_q, udf_d, udf_q, rd_valid_d, rd_valid_q;
  logic              wr_acc, rd_acc;

  // Reset masks the array ports so a mid-operation reset never writes memory.
  assign wr_acc = wr_en & ~full_q  & ~reset;
  assign rd_acc = rd_en & ~empty_q & ~reset;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    rd_valid_d = rd_acc;
    if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_FULL);
    empty_d = (count_d == '0);
    af_d    = (count_d >= CNT_AF);
    ovf_d   = clr_err ? 1'b0 : (ovf_q | (wr_en & full_q));
    udf_d   = clr_err ? 1'b0 : (udf_q | (rd_en & empty_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      af_q       <= 1'b0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      af_q       <= af_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  fifo_regfile #(
    .DATA_SIZE  (DATA_SIZE),
    .ADDR_DEPTH (ADDR_DEPTH)
  ) u_regfile (
    .clk   (clk),
    .reset (reset),
    .we    (wr_acc),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .re    (rd_acc),
    .raddr (rd_ptr_q),
    .rdata (rd_data)
  );

  assign wr_ptr      = wr_ptr_q;
  assign rd_ptr      = rd_ptr_q;
  assign fifo_count  = count_q;
  assign fifo_full   = full_q;
  assign fifo_empty  = empty_q;
  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
  assign rd_valid    = rd_valid_q;

endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: a reference FIFO queue feeds a
// scoreboard of expected read words, popped when rd_valid is due.
module tb_fifo_ptr_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_en = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] wr_ptr, rd_ptr;
  logic [3:0] fifo_count;
  logic       fifo_full, fifo_empty, almost_full, overflow, underflow;

  int checks = 0;
  int failures = 0;

  logic [7:0] m_fifo[$];
  logic [7:0] exp_q[$];
  int         m_wptr = 0;
  int         m_rptr = 0;

  always #5 clk = ~clk;

  fifo_ptr_ctrl #(
    .DATA_SIZE  (8),
    .ADDR_DEPTH (8),
    .AF_LEVEL   (6)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .clr_err     (clr_err),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .fifo_count  (fifo_count),
    .fifo_full   (fifo_full),
    .fifo_empty  (fifo_empty),
    .almost_full (almost_full),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  // Drive one clock of requests; the reference model decides acceptance
  // from its own occupancy and queues the word a read should return.
  task automatic cycle(input logic w, input logic [7:0] d, input logic r);
    bit wa, ra;
    wr_en = w; wr_data = d; rd_en = r;
    wa = w && (m_fifo.size() < 8);
    ra = r && (m_fifo.size() > 0);
    if (ra) begin
      exp_q.push_back(m_fifo.pop_front());
      m_rptr = (m_rptr + 1) % 8;
    end
    if (wa) begin
      m_fifo.push_back(d);
      m_wptr = (m_wptr + 1) % 8;
    end
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic do_reset(input logic w, input logic r);
    reset = 1'b1; wr_en = w; rd_en = r; wr_data = 8'hEE;
    @(posedge clk); #1;
    reset = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    m_fifo.delete(); exp_q.delete();
    m_wptr = 0; m_rptr = 0;
  endtask

  task automatic test_reset();
    do_reset(1'b0, 1'b0);
    checks++;
    if (fifo_count !== 4'd0 || wr_ptr !== 3'd0 || rd_ptr !== 3'd0) begin
      failures++;
      $display("FAIL reset_ptrs: count=%0d wr_ptr=%0d rd_ptr=%0d required 0/0/0", fifo_count, wr_ptr, rd_ptr);
    end
    checks++;
    if ({fifo_empty, fifo_full, almost_full, rd_valid, overflow, underflow} !== 6'b100000 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL reset_flags: e/f/af/v/ovf/udf=%b rd_data=%h required 100000/00",
               {fifo_empty, fifo_full, almost_full, rd_valid, overflow, underflow}, rd_data);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 8'h10 + 8'(i), 1'b0);
      checks++;
      if (fifo_count !== 4'(i + 1) || almost_full !== (i + 1 >= 6) || fifo_full !== (i + 1 == 8)
          || fifo_empty !== 1'b0) begin
        failures++;
        $display("FAIL fill_%0d: count=%0d af=%b full=%b empty=%b required %0d/%b/%b/0",
                 i, fifo_count, almost_full, fifo_full, fifo_empty, i + 1, (i + 1 >= 6), (i + 1 == 8));
      end
    end
    checks++;
    if (wr_ptr !== 3'(m_wptr) || wr_ptr !== 3'd0) begin
      failures++;
      $display("FAIL fill_wrap: wr_ptr=%0d required 0", wr_ptr);
    end
  endtask

  task automatic test_overflow();
    cycle(1'b1, 8'hAA, 1'b0);
    checks++;
    if (overflow !== 1'b1 || fifo_count !== 4'd8 || wr_ptr !== 3'd0 || fifo_full !== 1'b1) begin
      failures++;
      $display("FAIL overflow: ovf=%b count=%0d wr_ptr=%0d full=%b required 1/8/0/1",
               overflow, fifo_count, wr_ptr, fifo_full);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e || e !== 8'h10 + 8'(i)) begin
        failures++;
        $display("FAIL b2b_read_%0d: valid=%b data=%h required 1/%h", i, rd_valid, rd_data, 8'h10 + 8'(i));
      end
    end
    checks++;
    if (fifo_empty !== 1'b1 || rd_ptr !== 3'd0 || fifo_count !== 4'd0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL b2b_end: empty=%b rd_ptr=%0d count=%0d af=%b required 1/0/0/0",
               fifo_empty, rd_ptr, fifo_count, almost_full);
    end
    cycle(1'b0, 8'h00, 1'b0);
    checks++;
    if (rd_valid !== 1'b0 || rd_data !== 8'h17) begin
      failures++;
      $display("FAIL b2b_hold: valid=%b data=%h required 0/17", rd_valid, rd_data);
    end
  endtask

  task automatic test_underflow();
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0 || rd_ptr !== 3'd0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL underflow: udf=%b valid=%b rd_ptr=%0d required 1/0/0", underflow, rd_valid, rd_ptr);
    end
    clr_err = 1'b1;
    cycle(1'b0, 8'h00, 1'b0);
    clr_err = 1'b0;
    checks++;
    if (overflow !== 1'b0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL clr_err: ovf=%b udf=%b required 0/0", overflow, underflow);
    end
    clr_err = 1'b1;
    cycle(1'b0, 8'h00, 1'b1);
    clr_err = 1'b0;
    checks++;
    if (underflow !== 1'b0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_priority: udf=%b valid=%b required 0/0", underflow, rd_valid);
    end
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'h30 + 8'(i), 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h40 + 8'(i), 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (fifo_count !== 4'd3 || rd_valid !== 1'b1 || rd_data !== e) begin
        failures++;
        $display("FAIL simul_%0d: count=%0d valid=%b data=%h required 3/1/%h", i, fifo_count, rd_valid, rd_data, e);
      end
    end
    checks++;
    if (wr_ptr !== 3'd0 || rd_ptr !== 3'd5 || wr_ptr !== 3'(m_wptr) || rd_ptr !== 3'(m_rptr)) begin
      failures++;
      $display("FAIL simul_ptrs: wr_ptr=%0d rd_ptr=%0d required 0/5", wr_ptr, rd_ptr);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 8'h00, 1'b1);
      e = exp_q.pop_front();
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== e || e !== 8'h42 + 8'(i)) begin
        failures++;
        $display("FAIL simul_drain_%0d: valid=%b data=%h required 1/%h", i, rd_valid, rd_data, 8'h42 + 8'(i));
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) cycle(1'b1, 8'h60 + 8'(i), 1'b0);
    do_reset(1'b1, 1'b1);
    checks++;
    if (wr_ptr !== 3'd0 || rd_ptr !== 3'd0 || fifo_count !== 4'd0 || fifo_empty !== 1'b1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: wr_ptr=%0d rd_ptr=%0d count=%0d empty=%b valid=%b required 0/0/0/1/0",
               wr_ptr, rd_ptr, fifo_count, fifo_empty, rd_valid);
    end
    cycle(1'b0, 8'h00, 1'b1);
    checks++;
    if (underflow !== 1'b1 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_read: udf=%b valid=%b required 1/0", underflow, rd_valid);
    end
    cycle(1'b1, 8'h55, 1'b1);
    checks++;
    if (fifo_count !== 4'd1 || rd_valid !== 1'b0 || wr_ptr !== 3'd1 || rd_ptr !== 3'd0) begin
      failures++;
      $display("FAIL empty_both: count=%0d valid=%b wr_ptr=%0d rd_ptr=%0d required 1/0/1/0",
               fifo_count, rd_valid, wr_ptr, rd_ptr);
    end
    cycle(1'b0, 8'h00, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== e || e !== 8'h55) begin
      failures++;
      $display("FAIL empty_both_read: valid=%b data=%h required 1/55", rd_valid, rd_data);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    test_reset();
    test_fill();
    test_overflow();
    test_back_to_back();
    test_underflow();
    test_simultaneous();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
